axil_csr_bridge: RTL and testbench
==================================

# axil_csr_bridge

Parametrised AXI4-Lite slave converting Zynq PS register accesses into CSR write/read strobes for the accelerator register file. This generation improves on the single-port slave in five ways:
- independent write and read address ports, so writes and reads run concurrently;
- byte strobes passed through to the CSR block;
- configurable CSR read latency;
- SLVERR for accesses outside the implemented register window;
- a saturating error counter.

Sits between the PS GP port interconnect and the CSR block.

## Interface
- ADDR_WIDTH, 12, AXI byte-address width.
- DATA_WIDTH, 32, data width; 32 or 64 only.
- NUM_REGS, 64, implemented word registers. The word index is addr >> log2(DATA_WIDTH/8), and index < NUM_REGS is in range.
- RD_LATENCY, 1, cycles from csr_ren to csr_rdata valid; 0..3.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axi_aw{valid,ready,addr,prot}  in/out/in/in  1/1/ADDR_WIDTH/3  write address channel; prot ignored.
- s_axi_w{valid,ready,data,strb}  in/out/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel.
- s_axi_b{valid,ready,resp}  out/in/out  1/1/2  write response.
- s_axi_ar{valid,ready,addr,prot}  in/out/in/in  1/1/ADDR_WIDTH/3  read address channel; prot ignored.
- s_axi_r{valid,ready,data,resp}  out/in/out/out  1/1/DATA_WIDTH/2  read data/response.
- csr_wen  out  1  one-cycle write strobe.
- csr_waddr  out  ADDR_WIDTH  write byte address.
- csr_wdata  out  DATA_WIDTH  write data.
- csr_wstrb  out  DATA_WIDTH/8  write byte enables.
- csr_ren  out  1  one-cycle read strobe.
- csr_raddr  out  ADDR_WIDTH  read byte address.
- csr_rdata  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after csr_ren.
- err_count  out  16  saturating count of SLVERR responses.
- axi_error  out  1  one-cycle pulse on each SLVERR response issued.

## Operation
- Write path, states W_IDLE, W_RESP:
  - AW and W are accepted independently in any order and latched with flags got_aw and got_w.
  - awready = !got_aw && state==W_IDLE; wready = !got_w && state==W_IDLE.
  - When both flags are set, move to W_RESP, clear both flags and assert bvalid.
  - bresp = OKAY (2'b00) if in range, else SLVERR (2'b10).
  - csr_wen pulses in the first W_RESP cycle only if in range. csr_waddr, csr_wdata and csr_wstrb are held from the latches.
  - wstrb = 0 with an in-range address: csr_wen still pulses with csr_wstrb = 0, response OKAY.
  - bvalid is held until bready, then return to W_IDLE.
- Read path, states R_IDLE, R_WAIT, R_RESP:
  - arready = (state==R_IDLE). On handshake, latch araddr and go to R_WAIT.
  - In the first R_WAIT cycle, pulse csr_ren if in range. Count RD_LATENCY cycles, capture csr_rdata, go to R_RESP.
  - Out-of-range reads: no csr_ren, rdata = 0, rresp = SLVERR.
  - rvalid, rdata and rresp are held stable until rready, then return to R_IDLE.
- Write and read paths are fully independent. csr_wen and csr_ren may assert in the same cycle at different addresses.
- err_count increments once per SLVERR (write or read) and saturates at 16'hFFFF. If a write error and a read error issue in the same cycle, it adds 2, still saturating.
- Reset mid-transaction: all state returns to idle immediately. Latched requests are dropped and no strobe or response is emitted.

## Timing
- Reset values: awready=1, wready=1, arready=1; bvalid=0, rvalid=0, csr_wen=0, csr_ren=0, axi_error=0; bresp=rresp=2'b00; rdata, csr_waddr, csr_wdata, csr_wstrb, csr_raddr, err_count all 0.
- Write, with the later of the AW/W handshakes in cycle T:
  - csr_wen and bvalid both high in cycle T+1.
  - With bready held high, bvalid falls after T+1 and awready/wready return in T+2.
- Read, with the AR handshake in cycle T:
  - csr_ren high in T+1.
  - csr_rdata is sampled at the end of cycle T+1+RD_LATENCY.
  - rvalid rises in T+2+RD_LATENCY.
- Sustained throughput is one write every 2 cycles and one read every 3+RD_LATENCY cycles, with ready held high by the master.
- axi_error pulses in the cycle bvalid/rvalid first rises with SLVERR.

## Structure
- Package axil_pkg holds:
  - localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - typedef enums wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_WAIT, R_RESP}.
- Single flat module; no sub-module needed. The write and read FSMs are separate always_ff blocks.

## Test plan
- AW addr 0x010 and W data 0xDEADBEEF, strb 0xF, same cycle T -> csr_wen in T+1 with waddr 0x010, wdata 0xDEADBEEF; bresp OKAY.
- W presented 3 cycles before AW (addr 0x020, strb 0x3) -> wready low after the W handshake; a single csr_wen with wstrb 0x3 in the cycle after the AW handshake.
- RD_LATENCY=2, AR addr 0x004, csr model returns 0x12345678 -> csr_ren in T+1; rvalid in T+4 with rdata 0x12345678, OKAY.
- AR addr 0x100 with NUM_REGS=64 -> no csr_ren; rresp SLVERR, rdata 0; axi_error pulse; err_count=1.
- Out-of-range write and out-of-range read completing in the same cycle -> err_count += 2. Preload near 16'hFFFE -> saturates at 16'hFFFF.
- bready held low 5 cycles, then rst_n asserted mid-read -> bvalid held stable before reset. After reset all outputs match the reset values, and no csr_ren or csr_wen is emitted.

Source files
------------

// File: rtl/axil_csr_bridge_pkg.sv
// Shared response codes, FSM state types and the saturating error-count helper
// for the AXI4-Lite CSR bridge.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned ERR_CNT_WIDTH = 16;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    // Adds 0..2 error events, clamping at all-ones.
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_add_err(
        input logic [ERR_CNT_WIDTH-1:0] cnt,
        input logic [1:0]               inc
    );
        logic [ERR_CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(ERR_CNT_WIDTH - 1){1'b0}}, inc};
        return sum[ERR_CNT_WIDTH] ? '1 : sum[ERR_CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/axil_csr_bridge_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the CSR bridge (slave).
interface axil_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb,    input wready,
        input  bvalid, bresp,           output bready,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, rresp,    output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb,    output wready,
        output bvalid, bresp,           input bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp,    input rready
    );

endinterface

// File: rtl/axil_csr_bridge.sv
// AXI4-Lite slave turning PS register accesses into CSR write/read strobes,
// with independent write/read paths, SLVERR on out-of-window accesses and an error counter.
module axil_csr_bridge
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 64,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axil_if.slave                        s_axi,
    output logic                         csr_wen,
    output logic [ADDR_WIDTH-1:0]        csr_waddr,
    output logic [DATA_WIDTH-1:0]        csr_wdata,
    output logic [DATA_WIDTH/8-1:0]      csr_wstrb,
    output logic                         csr_ren,
    output logic [ADDR_WIDTH-1:0]        csr_raddr,
    input  logic [DATA_WIDTH-1:0]        csr_rdata,
    output logic [ERR_CNT_WIDTH-1:0]     err_count,
    output logic                         axi_error
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int unsigned LAT_WIDTH  = 2;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return 32'(addr >> BYTE_SHIFT) < NUM_REGS;
    endfunction

    logic unused_prot;
    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

    // ---------------- write path ----------------
    wr_state_t             w_state, w_state_n;
    logic                  got_aw, got_aw_n, got_w, got_w_n;
    logic                  awready_n, wready_n, bvalid_n, wen_n, w_err_c;
    logic [1:0]            bresp_n;
    logic [ADDR_WIDTH-1:0] waddr_n;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [STRB_WIDTH-1:0] wstrb_n;

    // AW and W latch independently; the response fires once both are held.
    always_comb begin
        w_state_n = w_state;
        got_aw_n  = got_aw;
        got_w_n   = got_w;
        waddr_n   = csr_waddr;
        wdata_n   = csr_wdata;
        wstrb_n   = csr_wstrb;
        bvalid_n  = s_axi.bvalid;
        bresp_n   = s_axi.bresp;
        wen_n     = 1'b0;
        w_err_c   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (s_axi.awvalid && s_axi.awready) begin
                    got_aw_n = 1'b1;
                    waddr_n  = s_axi.awaddr;
                end
                if (s_axi.wvalid && s_axi.wready) begin
                    got_w_n = 1'b1;
                    wdata_n = s_axi.wdata;
                    wstrb_n = s_axi.wstrb;
                end
                if (got_aw_n && got_w_n) begin
                    w_state_n = W_RESP;
                    got_aw_n  = 1'b0;
                    got_w_n   = 1'b0;
                    bvalid_n  = 1'b1;
                    bresp_n   = in_range(waddr_n) ? RESP_OKAY : RESP_SLVERR;
                    wen_n     = in_range(waddr_n);
                    w_err_c   = !in_range(waddr_n);
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_n = W_IDLE;
                    bvalid_n  = 1'b0;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        awready_n = !got_aw_n && (w_state_n == W_IDLE);
        wready_n  = !got_w_n && (w_state_n == W_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            got_aw        <= 1'b0;
            got_w         <= 1'b0;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
            csr_wen       <= 1'b0;
            csr_waddr     <= '0;
            csr_wdata     <= '0;
            csr_wstrb     <= '0;
        end else begin
            w_state       <= w_state_n;
            got_aw        <= got_aw_n;
            got_w         <= got_w_n;
            s_axi.awready <= awready_n;
            s_axi.wready  <= wready_n;
            s_axi.bvalid  <= bvalid_n;
            s_axi.bresp   <= bresp_n;
            csr_wen       <= wen_n;
            csr_waddr     <= waddr_n;
            csr_wdata     <= wdata_n;
            csr_wstrb     <= wstrb_n;
        end
    end

    // ---------------- read path ----------------
    rd_state_t             r_state, r_state_n;
    logic [LAT_WIDTH-1:0]  lat_cnt, lat_cnt_n;
    logic                  rd_ok, rd_ok_n;
    logic                  arready_n, rvalid_n, ren_n, r_err_c;
    logic [1:0]            rresp_n;
    logic [ADDR_WIDTH-1:0] raddr_n;
    logic [DATA_WIDTH-1:0] rdata_n;

    // R_WAIT spans RD_LATENCY+1 cycles: the strobe cycle plus the CSR latency.
    always_comb begin
        r_state_n = r_state;
        lat_cnt_n = lat_cnt;
        rd_ok_n   = rd_ok;
        raddr_n   = csr_raddr;
        rvalid_n  = s_axi.rvalid;
        rdata_n   = s_axi.rdata;
        rresp_n   = s_axi.rresp;
        ren_n     = 1'b0;
        r_err_c   = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (s_axi.arvalid && s_axi.arready) begin
                    r_state_n = R_WAIT;
                    raddr_n   = s_axi.araddr;
                    rd_ok_n   = in_range(s_axi.araddr);
                    ren_n     = in_range(s_axi.araddr);
                    lat_cnt_n = '0;
                end
            end
            R_WAIT: begin
                if (lat_cnt == LAT_WIDTH'(RD_LATENCY)) begin
                    r_state_n = R_RESP;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_ok ? csr_rdata : '0;
                    rresp_n   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    r_err_c   = !rd_ok;
                end else begin
                    lat_cnt_n = lat_cnt + LAT_WIDTH'(1);
                end
            end
            R_RESP: begin
                if (s_axi.rready) begin
                    r_state_n = R_IDLE;
                    rvalid_n  = 1'b0;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        arready_n = (r_state_n == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= R_IDLE;
            lat_cnt       <= '0;
            rd_ok         <= 1'b0;
            s_axi.arready <= 1'b1;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
            csr_ren       <= 1'b0;
            csr_raddr     <= '0;
        end else begin
            r_state       <= r_state_n;
            lat_cnt       <= lat_cnt_n;
            rd_ok         <= rd_ok_n;
            s_axi.arready <= arready_n;
            s_axi.rvalid  <= rvalid_n;
            s_axi.rdata   <= rdata_n;
            s_axi.rresp   <= rresp_n;
            csr_ren       <= ren_n;
            csr_raddr     <= raddr_n;
        end
    end

    // ---------------- error accounting ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            axi_error <= 1'b0;
        end else begin
            err_count <= sat_add_err(err_count, {1'b0, w_err_c} + {1'b0, r_err_c});
            axi_error <= w_err_c | r_err_c;
        end
    end

endmodule

// File: tb/tb_axil_csr_bridge.sv
// Directed bench for axil_csr_bridge: vector table of single accesses plus
// hand-written sequences for ordering, concurrency, saturation and reset.
module tb_axil_csr_bridge;
    import axil_pkg::*;

    localparam int unsigned AW     = 12;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_wen, csr_ren, axi_error;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, csr_rdata;
    logic [3:0]  csr_wstrb;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;

    axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();

    axil_csr_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(64), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axi(s_axi),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
        .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .err_count(err_count), .axi_error(axi_error)
    );

    always #5 clk = ~clk;

    // CSR register file: byte-masked writes, two-stage read pipe that only carries
    // real data when csr_ren was asserted two cycles earlier.
    logic [31:0] mem [64];
    logic [31:0] rd_p0 = 32'hBAD0BAD0;
    logic [31:0] rd_p1 = 32'hBAD0BAD0;
    always @(posedge clk) begin
        if (csr_wen)
            for (int b = 0; b < 4; b++)
                if (csr_wstrb[b]) mem[csr_waddr[7:2]][8*b +: 8] <= csr_wdata[8*b +: 8];
        rd_p0 <= csr_ren ? mem[csr_raddr[7:2]] : 32'hBAD0BAD0;
        rd_p1 <= rd_p0;
        if (csr_wen) wen_cnt <= wen_cnt + 1;
        if (csr_ren) ren_cnt <= ren_cnt + 1;
    end
    assign csr_rdata = rd_p1;

    typedef struct {
        logic        is_wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic        exp_strobe;
        logic [31:0] exp_rdata;
        logic [15:0] exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);
        check({tag, "_valid_strobes"}, {s_axi.bvalid, s_axi.rvalid, csr_wen, csr_ren, axi_error}, 5'b0);
        check({tag, "_resp"}, {s_axi.bresp, s_axi.rresp}, 4'b0);
        check({tag, "_rdata"}, s_axi.rdata, 0);
        check({tag, "_csr_w"}, {csr_waddr, csr_wdata, csr_wstrb}, 0);
        check({tag, "_csr_raddr"}, csr_raddr, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input logic exp_wen, input logic [15:0] exp_err);
        int w0;
        w0 = wen_cnt;
        @(negedge clk);
        check("wr_ready_idle", {s_axi.awready, s_axi.wready}, 2'b11);
        s_axi.awvalid = 1'b1; s_axi.awaddr = addr;
        s_axi.wvalid  = 1'b1; s_axi.wdata = data; s_axi.wstrb = strb;
        s_axi.bready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        check("wr_bvalid", s_axi.bvalid, 1'b1);
        check("wr_bresp", s_axi.bresp, exp_resp);
        check("wr_wen", csr_wen, exp_wen);
        check("wr_axi_error", axi_error, exp_resp == RESP_SLVERR);
        check("wr_err_count", err_count, exp_err);
        check("wr_ready_busy", {s_axi.awready, s_axi.wready}, 2'b00);
        if (exp_wen) begin
            check("wr_waddr", csr_waddr, addr);
            check("wr_wdata", csr_wdata, data);
            check("wr_wstrb", csr_wstrb, strb);
        end
        @(negedge clk);
        check("wr_bvalid_drop", s_axi.bvalid, 1'b0);
        check("wr_ready_back", {s_axi.awready, s_axi.wready}, 2'b11);
        check("wr_wen_count", wen_cnt - w0, exp_wen);
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [1:0] exp_resp, input logic exp_ren,
                           input logic [31:0] exp_data, input logic [15:0] exp_err);
        int r0;
        int lat;
        r0 = ren_cnt;
        @(negedge clk);
        check("rd_arready_idle", s_axi.arready, 1'b1);
        s_axi.arvalid = 1'b1; s_axi.araddr = addr; s_axi.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        check("rd_ren", csr_ren, exp_ren);
        check("rd_arready_busy", s_axi.arready, 1'b0);
        if (exp_ren) check("rd_raddr", csr_raddr, addr);
        lat = 1;
        while (!s_axi.rvalid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", lat, 4);
        check("rd_rdata", s_axi.rdata, exp_data);
        check("rd_rresp", s_axi.rresp, exp_resp);
        check("rd_axi_error", axi_error, exp_resp == RESP_SLVERR);
        check("rd_err_count", err_count, exp_err);
        @(negedge clk);
        check("rd_rvalid_drop", s_axi.rvalid, 1'b0);
        check("rd_arready_back", s_axi.arready, 1'b1);
        check("rd_ren_count", ren_cnt - r0, exp_ren);
    endtask

    // Out-of-range read issued 3 cycles before an out-of-range write so both responses rise together.
    task automatic do_double_err(input logic [15:0] exp_err);
        int w0, r0;
        w0 = wen_cnt; r0 = ren_cnt;
        @(negedge clk);
        s_axi.arvalid = 1'b1; s_axi.araddr = 12'h200; s_axi.rready = 1'b1; s_axi.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s_axi.awvalid = 1'b1; s_axi.awaddr = 12'h300;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h0; s_axi.wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        check("dbl_both_valid", {s_axi.bvalid, s_axi.rvalid}, 2'b11);
        check("dbl_resps", {s_axi.bresp, s_axi.rresp}, {RESP_SLVERR, RESP_SLVERR});
        check("dbl_rdata", s_axi.rdata, 0);
        check("dbl_axi_error", axi_error, 1'b1);
        check("dbl_err_count", err_count, exp_err);
        @(negedge clk);
        check("dbl_axi_error_drop", axi_error, 1'b0);
        check("dbl_valid_drop", {s_axi.bvalid, s_axi.rvalid}, 2'b00);
        check("dbl_no_strobes", (wen_cnt - w0) + (ren_cnt - r0), 0);
    endtask

    initial begin
        int n, w0, r0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1] = 32'h12345678;
        rst_n = 1'b0;
        s_axi.awvalid = 1'b0; s_axi.awaddr = '0; s_axi.awprot = 3'b0;
        s_axi.wvalid  = 1'b0; s_axi.wdata  = '0; s_axi.wstrb  = '0;
        s_axi.bready  = 1'b0;
        s_axi.arvalid = 1'b0; s_axi.araddr = '0; s_axi.arprot = 3'b0;
        s_axi.rready  = 1'b0;

        vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, RESP_OKAY,   1'b1, 32'h0,        16'd0};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,        4'h0, RESP_OKAY,   1'b1, 32'h12345678, 16'd0};
        vecs[2]  = '{1'b0, 12'h010, 32'h0,        4'h0, RESP_OKAY,   1'b1, 32'hDEADBEEF, 16'd0};
        vecs[3]  = '{1'b1, 12'h010, 32'h00000000, 4'h0, RESP_OKAY,   1'b1, 32'h0,        16'd0};
        vecs[4]  = '{1'b0, 12'h010, 32'h0,        4'h0, RESP_OKAY,   1'b1, 32'hDEADBEEF, 16'd0};
        vecs[5]  = '{1'b1, 12'h0FC, 32'hA5A5A5A5, 4'hF, RESP_OKAY,   1'b1, 32'h0,        16'd0};
        vecs[6]  = '{1'b0, 12'h0FC, 32'h0,        4'h0, RESP_OKAY,   1'b1, 32'hA5A5A5A5, 16'd0};
        vecs[7]  = '{1'b0, 12'h100, 32'h0,        4'h0, RESP_SLVERR, 1'b0, 32'h0,        16'd1};
        vecs[8]  = '{1'b1, 12'h100, 32'h11111111, 4'hF, RESP_SLVERR, 1'b0, 32'h0,        16'd2};
        vecs[9]  = '{1'b1, 12'h004, 32'hFFFFFFFF, 4'h1, RESP_OKAY,   1'b1, 32'h0,        16'd2};
        vecs[10] = '{1'b0, 12'h004, 32'h0,        4'h0, RESP_OKAY,   1'b1, 32'h123456FF, 16'd2};
        vecs[11] = '{1'b1, 12'h014, 32'h12340000, 4'hC, RESP_OKAY,   1'b1, 32'h0,        16'd2};
        vecs[12] = '{1'b0, 12'h014, 32'h0,        4'h0, RESP_OKAY,   1'b1, 32'h12340000, 16'd2};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("post_reset_idle");

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_resp,
                         vecs[i].exp_strobe, vecs[i].exp_err);
            else
                do_read(vecs[i].addr, vecs[i].exp_resp, vecs[i].exp_strobe,
                        vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // W three cycles ahead of AW
        w0 = wen_cnt;
        @(negedge clk);
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'hCAFEF00D; s_axi.wstrb = 4'h3; s_axi.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi.wvalid = 1'b0;
        check("wfirst_wready_low", s_axi.wready, 1'b0);
        check("wfirst_awready_high", s_axi.awready, 1'b1);
        check("wfirst_no_resp", {s_axi.bvalid, csr_wen}, 2'b00);
        @(negedge clk);
        check("wfirst_hold", {s_axi.wready, s_axi.bvalid, csr_wen}, 3'b000);
        @(negedge clk);
        s_axi.awvalid = 1'b1; s_axi.awaddr = 12'h020;
        @(posedge clk);
        @(negedge clk);
        s_axi.awvalid = 1'b0;
        check("wfirst_wen", {csr_wen, s_axi.bvalid}, 2'b11);
        check("wfirst_waddr", csr_waddr, 12'h020);
        check("wfirst_wstrb", csr_wstrb, 4'h3);
        check("wfirst_wdata", csr_wdata, 32'hCAFEF00D);
        @(negedge clk);
        check("wfirst_single_wen", wen_cnt - w0, 1);
        do_read(12'h020, RESP_OKAY, 1'b1, 32'h0000F00D, 16'd2);

        // concurrent in-range write and read strobe in the same cycle
        @(negedge clk);
        s_axi.awvalid = 1'b1; s_axi.awaddr = 12'h030;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h55AA55AA; s_axi.wstrb = 4'hF;
        s_axi.arvalid = 1'b1; s_axi.araddr = 12'h0FC;
        s_axi.bready = 1'b1; s_axi.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
        check("conc_strobes", {csr_wen, csr_ren}, 2'b11);
        check("conc_addrs", {csr_waddr, csr_raddr}, {12'h030, 12'h0FC});
        n = 1;
        while (!s_axi.rvalid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("conc_rd_latency", n, 4);
        check("conc_rdata", s_axi.rdata, 32'hA5A5A5A5);
        @(negedge clk);
        do_read(12'h030, RESP_OKAY, 1'b1, 32'h55AA55AA, 16'd2);

        // simultaneous write+read errors, then saturation from a preloaded count
        do_double_err(16'd4);
        @(negedge clk);
        force dut.err_count = 16'hFFFE;
        #1 release dut.err_count;
        do_double_err(16'hFFFF);
        do_read(12'h100, RESP_SLVERR, 1'b0, 32'h0, 16'hFFFF);

        // bready stall then reset in the middle of a read
        @(negedge clk);
        s_axi.bready = 1'b0;
        s_axi.awvalid = 1'b1; s_axi.awaddr = 12'h040;
        s_axi.wvalid = 1'b1; s_axi.wdata = 32'h0BADF00D; s_axi.wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        check("stall_first", {s_axi.bvalid, csr_wen}, 2'b11);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_hold", {s_axi.bvalid, s_axi.bresp, csr_wen, s_axi.awready}, {1'b1, RESP_OKAY, 1'b0, 1'b0});
        end
        s_axi.arvalid = 1'b1; s_axi.araddr = 12'h008; s_axi.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        check("rst_seq_ren", csr_ren, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        w0 = wen_cnt; r0 = ren_cnt;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s_axi.bready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("after_reset_quiet", {s_axi.bvalid, s_axi.rvalid, csr_wen, csr_ren}, 4'b0);
        end
        check("after_reset_no_strobes", (wen_cnt - w0) + (ren_cnt - r0), 0);
        check_reset_values("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
